cv32e40p_pmu_sleep_handshake: RTL and testbench
===============================================

// Module: cv32e40p_pmu_sleep_handshake
// PURPOSE
//  Downstream consumer of the core sleep indication (core_sleep). Converts a stable core-sleep
//  condition into a 4-phase clock-stop request/acknowledge handshake with the SoC power
//  management unit (PMU). Filters short sleeps with an idle-cycle hysteresis and signals wake-up
//  completion back to the SoC. Runs on the free-running (ungated) clock, never on the core clock.
// PARAMETERS
//  IDLE_CYCLES  16  consecutive qualified sleep cycles before request; 0..255; 0 = request immediately
//  STAT_W       32  width of sleep-cycle statistics counter (used only with CV32E40P_SLEEP_STATS_EN)
// PORTS
//  clk_ungated_i   in   1       free-running clock
//  rst_i           in   1       one clock; reset is asynchronous and active-high
//  core_sleep_i    in   1       core sleep indication from sleep unit
//  wake_req_i      in   1       pending wake source (irq/debug), level
//  pwr_req_o       out  1       clock-stop request to PMU (registered)
//  pwr_ack_i       in   1       PMU acknowledge, 4-phase
//  clk_off_o       out  1       high while PMU has stopped the core clock (registered)
//  wake_o          out  1       1-cycle pulse on handshake completion after release
//  state_o         out  3       FSM state encoding (debug visibility)
//  sleep_cycles_o  out  STAT_W  cycles spent in GATED (macro only, else constant 0)
// BEHAVIOUR
//  - Reset (rst_i=1, async): state=ACTIVE, cnt=0, pwr_req_o=0, clk_off_o=0, wake_o=0,
//    sleep_cycles_o=0. All outputs registered or state-decoded; no comb path input->output.
//  - qual = core_sleep_i & ~wake_req_i.
//  - ACTIVE(0): req=0. qual -> IDLE (cnt=0); if IDLE_CYCLES==0, qual -> REQ directly.
//  - IDLE(1): req=0. ~qual -> ACTIVE, cnt cleared. qual: cnt++; cnt==IDLE_CYCLES-1 -> REQ.
//    Hence pwr_req_o rises IDLE_CYCLES+1 clock edges after qual is first sampled high.
//  - REQ(2): req=1. ~qual -> RELEASE (abort; wake has priority over simultaneous ack).
//    Else pwr_ack_i -> GATED.
//  - GATED(3): req=1, clk_off_o=1. ~qual -> RELEASE.
//  - RELEASE(4): req=0. Wait pwr_ack_i==0 -> ACTIVE, asserting wake_o for exactly that one
//    cycle. If ack is already 0 on entry, the transition happens on the next edge.
//  - Handshake rules: req never drops while in REQ/GATED except via RELEASE. A new req is
//    never raised while ack=1 (RELEASE gates). ack rising while not in REQ is ignored.
//  - cnt is 8 bit and never wraps: it clears on leaving IDLE.
//  - Reset mid-handshake: req drops asynchronously. The PMU must restart the clock on
//    req falling regardless of ack.
//  - Unused encodings 5..7 -> ACTIVE on next edge.
// CONFIGURATION
//  CV32E40P_SLEEP_STATS_EN defined:
//    - sleep_cycles_o counts +1 per clock in GATED, saturating at all-ones.
//    - It holds value otherwise and clears only on reset.
//  Not defined:
//    - Counter is not instantiated; sleep_cycles_o = '0.
//    - FSM behaviour is identical either way.
// TESTING
//  1. IDLE_CYCLES=4, core_sleep_i=1, wake_req_i=0 from edge 0 -> pwr_req_o=1 after edge 5,
//     state_o=2.
//  2. IDLE_CYCLES=4, core_sleep_i drops after 2 IDLE cycles -> state ACTIVE, pwr_req_o stays 0.
//     Re-sleep restarts the full 4-cycle count.
//  3. In REQ, ack=1 after 3 cycles -> GATED, clk_off_o=1.
//     Then wake_req_i 1-cycle pulse -> pwr_req_o=0 and clk_off_o=0 next edge.
//     ack=0 two cycles later -> wake_o=1 for one cycle, state ACTIVE.
//  4. In REQ, wake_req_i=1 and pwr_ack_i=1 same cycle -> RELEASE, clk_off_o never 1.
//     wake_o pulses once ack=0.
//  5. rst_i pulsed asynchronously (between edges) while GATED -> pwr_req_o, clk_off_o,
//     state_o = 0 before next edge.
//  6. Macro on: 10 cycles in GATED -> sleep_cycles_o=10; STAT_W=4 with 20 cycles -> 15.
//     Macro off -> 0.

Source files
------------

// File: rtl/cv32e40p_pmu_sleep_handshake.sv
// Turns a stable core-sleep condition into a 4-phase clock-stop req/ack handshake with the PMU.
// Latency: pwr_req_o rises IDLE_CYCLES+1 edges after qual; all outputs registered or state-decoded.
// Flow: pwr_ack_i stalls GATED entry and RELEASE exit; optional CV32E40P_SLEEP_STATS_EN adds a gated-cycle counter.
module cv32e40p_pmu_sleep_handshake #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk_ungated_i,
    input  logic              rst_i,
    input  logic              core_sleep_i,
    input  logic              wake_req_i,
    output logic              pwr_req_o,
    input  logic              pwr_ack_i,
    output logic              clk_off_o,
    output logic              wake_o,
    output logic [2:0]        state_o,
    output logic [STAT_W-1:0] sleep_cycles_o
);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_REQ     = 3'd2,
        ST_GATED   = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Last count value before the request; unused when IDLE_CYCLES is 0.
    localparam logic [7:0] CNT_LAST = (IDLE_CYCLES == 0) ? 8'd0 : 8'(IDLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic       clk_off_q, clk_off_d;
    logic       wake_q, wake_d;
    logic       qual;

    assign qual = core_sleep_i & ~wake_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                cnt_d = 8'd0;
                if (qual) begin
                    state_d = (IDLE_CYCLES == 0) ? ST_REQ : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!qual) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_REQ;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_REQ: begin
                // A wake request aborts even when the ack arrives in the same cycle.
                if (!qual) begin
                    state_d = ST_RELEASE;
                end else if (pwr_ack_i) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                if (!qual) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!pwr_ack_i) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        req_d     = (state_d == ST_REQ) || (state_d == ST_GATED);
        clk_off_d = (state_d == ST_GATED);
        wake_d    = (state_q == ST_RELEASE) && !pwr_ack_i;
    end

    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_ACTIVE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            clk_off_q <= 1'b0;
            wake_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            clk_off_q <= clk_off_d;
            wake_q    <= wake_d;
        end
    end

    assign pwr_req_o = req_q;
    assign clk_off_o = clk_off_q;
    assign wake_o    = wake_q;
    assign state_o   = state_q;

`ifdef CV32E40P_SLEEP_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;

    // Saturating count of clocks spent with the core clock stopped.
    always_comb begin
        stat_d = stat_q;
        if ((state_q == ST_GATED) && (stat_q != {STAT_W{1'b1}})) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= {STAT_W{1'b0}};
        end else begin
            stat_q <= stat_d;
        end
    end

    assign sleep_cycles_o = stat_q;
`else
    assign sleep_cycles_o = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cv32e40p_pmu_sleep_handshake.sv
// Directed bench: vector table for the handshake FSM plus hand sequences for async reset and statistics.
module tb_cv32e40p_pmu_sleep_handshake;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sleep_a = 1'b0, wake_a = 1'b0, ack_a = 1'b0;
    logic       req_a, off_a, wo_a;
    logic [2:0] st_a;
    logic [7:0] stat_a;
    logic       sleep_b = 1'b0, wake_b = 1'b0, ack_b = 1'b0;
    logic       req_b, off_b, wo_b;
    logic [2:0] st_b;
    logic [3:0] stat_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40p_pmu_sleep_handshake #(.IDLE_CYCLES(4), .STAT_W(8)) dut_a (
        .clk_ungated_i (clk),
        .rst_i         (rst),
        .core_sleep_i  (sleep_a),
        .wake_req_i    (wake_a),
        .pwr_req_o     (req_a),
        .pwr_ack_i     (ack_a),
        .clk_off_o     (off_a),
        .wake_o        (wo_a),
        .state_o       (st_a),
        .sleep_cycles_o(stat_a)
    );

    cv32e40p_pmu_sleep_handshake #(.IDLE_CYCLES(0), .STAT_W(4)) dut_b (
        .clk_ungated_i (clk),
        .rst_i         (rst),
        .core_sleep_i  (sleep_b),
        .wake_req_i    (wake_b),
        .pwr_req_o     (req_b),
        .pwr_ack_i     (ack_b),
        .clk_off_o     (off_b),
        .wake_o        (wo_b),
        .state_o       (st_b),
        .sleep_cycles_o(stat_b)
    );

    typedef struct {
        logic       sleep;
        logic       wake;
        logic       ack;
        logic       rst;
        logic       req;
        logic       off;
        logic       wo;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

`ifdef CV32E40P_SLEEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic add(input int sl, input int wk, input int ak, input int rs,
                       input int rq, input int of, input int wo, input int st);
        vec_t v;
        v.sleep = 1'(sl); v.wake = 1'(wk); v.ack = 1'(ak); v.rst = 1'(rs);
        v.req   = 1'(rq); v.off  = 1'(of); v.wo  = 1'(wo); v.st  = 3'(st);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit hit;

        //   sl wk ak rs   rq of wo st
        add(0, 0, 0, 1,   0, 0, 0, 0);   // reset state
        add(1, 0, 0, 0,   0, 0, 0, 1);   // idle count starts
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   1, 0, 0, 2);   // request on 5th edge
        add(1, 0, 0, 0,   1, 0, 0, 2);
        add(1, 0, 0, 0,   1, 0, 0, 2);
        add(1, 0, 1, 0,   1, 1, 0, 3);   // ack -> gated
        add(1, 0, 1, 0,   1, 1, 0, 3);
        add(1, 1, 1, 0,   0, 0, 0, 4);   // wake pulse -> release
        add(1, 0, 1, 0,   0, 0, 0, 4);
        add(1, 0, 1, 0,   0, 0, 0, 4);
        add(1, 0, 0, 0,   0, 0, 1, 0);   // ack low -> wake pulse
        add(0, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 1);   // short sleep
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0,   0, 0, 0, 0);   // aborted before request
        add(1, 0, 0, 0,   0, 0, 0, 1);   // full count restarts
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0,   1, 0, 0, 2);
        add(1, 1, 1, 0,   0, 0, 0, 4);   // wake beats simultaneous ack
        add(1, 0, 1, 0,   0, 0, 0, 4);
        add(1, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0);   // stray ack ignored
        add(1, 1, 0, 0,   0, 0, 0, 0);   // pending wake blocks sleep
        add(0, 0, 0, 0,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            sleep_a = vecs[i].sleep;
            wake_a  = vecs[i].wake;
            ack_a   = vecs[i].ack;
            rst     = vecs[i].rst;
            tick();
            chk($sformatf("v%0d_state", i), int'(st_a),  int'(vecs[i].st));
            chk($sformatf("v%0d_req", i),   int'(req_a), int'(vecs[i].req));
            chk($sformatf("v%0d_off", i),   int'(off_a), int'(vecs[i].off));
            chk($sformatf("v%0d_wake", i),  int'(wo_a),  int'(vecs[i].wo));
        end

        // Clear statistics with an asynchronous pulse, then sleep through to GATED.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("stat_cleared", int'(stat_a), 0);
        chk("b_reset_state", int'(st_b), 0);
        chk("b_reset_req", int'(req_b), 0);
        sleep_a = 1'b1;
        n = 0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick();
            n++;
            if (req_a) hit = 1'b1;
        end
        chk("req_timeout", int'(hit), 1);
        chk("req_latency", n, 5);
        ack_a = 1'b1;
        tick();
        chk("gated_state", int'(st_a), 3);
        chk("gated_off", int'(off_a), 1);
        for (int k = 0; k < 10; k++) tick();
        chk("stat_10", int'(stat_a), STATS ? 10 : 0);

        // Asynchronous reset between edges while gated.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", int'(req_a), 0);
        chk("arst_off", int'(off_a), 0);
        chk("arst_state", int'(st_a), 0);
        chk("arst_stat", int'(stat_a), 0);
        sleep_a = 1'b0;
        ack_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Zero-hysteresis instance: request on the first edge, then saturate the 4-bit counter.
        sleep_b = 1'b1;
        tick();
        chk("b_req_immediate", int'(req_b), 1);
        chk("b_state_req", int'(st_b), 2);
        ack_b = 1'b1;
        tick();
        chk("b_gated", int'(st_b), 3);
        for (int k = 0; k < 20; k++) tick();
        chk("b_stat_sat", int'(stat_b), STATS ? 15 : 0);
        wake_b = 1'b1;
        tick();
        chk("b_release", int'(st_b), 4);
        ack_b = 1'b0;
        tick();
        chk("b_wake_pulse", int'(wo_b), 1);
        chk("b_stat_hold", int'(stat_b), STATS ? 15 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
